// File: rtl/riscv_if_aligner_fifo_pkg.sv
// Shared types and helpers for the IF-stage aligner FIFO.
package riscv_if_pkg;

  localparam int unsigned ILEN = 32;

  // Low two bits of a halfword that mark a full-length (uncompressed) instruction
  localparam logic [1:0] RVC_UNCOMP = 2'b11;

  typedef enum logic [1:0] {
    S_ALIGNED = 2'd0,
    S_HALF    = 2'd1,
    S_SKIP    = 2'd2
  } align_state_e;

  // True when the halfword starts a 16-bit compressed instruction
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != RVC_UNCOMP;
  endfunction

endpackage

// File: rtl/riscv_if_aligner_fifo_if.sv
// Fetch-side and decode-side handshake bundle of the aligner FIFO.
interface riscv_if_aligner_fifo_if #(
  parameter int unsigned PC_WIDTH = 32
);

  logic                branch_i;
  logic [PC_WIDTH-1:0] branch_addr_i;
  logic                fetch_valid_i;
  logic                fetch_ready_o;
  logic [31:0]         fetch_rdata_i;
  logic [PC_WIDTH-1:0] fetch_addr_i;
  logic                instr_valid_o;
  logic                instr_ready_i;
  logic [31:0]         instr_rdata_o;
  logic [PC_WIDTH-1:0] instr_pc_o;
  logic                instr_is_compressed_o;
  logic                busy_o;

  // Surrounding pipeline: prefetch buffer and IF/ID register
  modport master (
    output branch_i, branch_addr_i, fetch_valid_i, fetch_rdata_i, fetch_addr_i, instr_ready_i,
    input  fetch_ready_o, instr_valid_o, instr_rdata_o, instr_pc_o, instr_is_compressed_o, busy_o
  );

  // The aligner itself
  modport slave (
    input  branch_i, branch_addr_i, fetch_valid_i, fetch_rdata_i, fetch_addr_i, instr_ready_i,
    output fetch_ready_o, instr_valid_o, instr_rdata_o, instr_pc_o, instr_is_compressed_o, busy_o
  );

endinterface

// File: rtl/riscv_if_aligner_fifo_fifo.sv
// Word FIFO holding {address, data} pairs between prefetch and aligner.
module riscv_if_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/riscv_if_aligner_fifo.sv
// IF-stage fetch FIFO with RVC realignment: emits one raw instruction plus PC
// per handshake. Optional zero-latency bypass: RISCV_IF_ALIGNER_BYPASS_EN.
module riscv_if_aligner_fifo
  import riscv_if_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  riscv_if_aligner_fifo_if.slave bus
);

  localparam int unsigned EW = PC_WIDTH + ILEN;

  localparam logic [1:0] ST_ALIGNED = 2'(S_ALIGNED);
  localparam logic [1:0] ST_HALF    = 2'(S_HALF);
  localparam logic [1:0] ST_SKIP    = 2'(S_SKIP);

  logic [1:0]          state_q, state_d;
  logic [15:0]         hold_q, hold_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                hold_vld_q, hold_vld_d;

  logic                fifo_full, fifo_empty;
  logic [EW-1:0]       fifo_rdata;
  logic                fifo_push_c, fifo_pop_c;
  logic                push_req_c, pop_c, bypass_c;
  logic                head_vld_c;
  logic [ILEN-1:0]     head_word_c;
  logic [PC_WIDTH-1:0] head_addr_c;
  logic                valid_c;
  logic [ILEN-1:0]     data_c;
  logic [PC_WIDTH-1:0] pc_c;
  logic                unused_c;

  // Only bit 1 of the branch target matters; the data carries its own address
  assign unused_c = ^{bus.branch_addr_i[PC_WIDTH-1:2], bus.branch_addr_i[0]};

  assign push_req_c = bus.fetch_valid_i & ~fifo_full & ~bus.branch_i;

`ifdef RISCV_IF_ALIGNER_BYPASS_EN
  logic xfer_c;
  // An empty FIFO in S_ALIGNED lets the incoming word feed the output directly
  assign bypass_c    = fifo_empty & (state_q == ST_ALIGNED) & push_req_c;
  assign head_vld_c  = ~fifo_empty | bypass_c;
  assign head_word_c = bypass_c ? bus.fetch_rdata_i : fifo_rdata[ILEN-1:0];
  assign head_addr_c = bypass_c ? bus.fetch_addr_i  : fifo_rdata[EW-1:ILEN];
  assign xfer_c      = valid_c & bus.instr_ready_i & ~bus.branch_i;
  assign fifo_push_c = push_req_c & ~(bypass_c & xfer_c);
`else
  assign bypass_c    = 1'b0;
  assign head_vld_c  = ~fifo_empty;
  assign head_word_c = fifo_rdata[ILEN-1:0];
  assign head_addr_c = fifo_rdata[EW-1:ILEN];
  assign fifo_push_c = push_req_c;
`endif

  assign fifo_pop_c = pop_c & ~bypass_c;

  riscv_if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.branch_i),
    .push  (fifo_push_c),
    .wdata ({bus.fetch_addr_i, bus.fetch_rdata_i}),
    .pop   (fifo_pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Aligner state and halfword hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ALIGNED;
      hold_q     <= '0;
      hold_pc_q  <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_pc_q  <= hold_pc_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  // Next-state, FIFO pop and output instruction selection
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_pc_d  = hold_pc_q;
    hold_vld_d = hold_vld_q;
    pop_c      = 1'b0;
    valid_c    = 1'b0;
    data_c     = '0;
    pc_c       = '0;

    case (state_q)
      ST_ALIGNED: begin
        valid_c = head_vld_c;
        pc_c    = head_addr_c;
        if (is_rvc(head_word_c[15:0])) begin
          data_c = {16'h0, head_word_c[15:0]};
          if (valid_c && bus.instr_ready_i) begin
            pop_c      = 1'b1;
            hold_d     = head_word_c[31:16];
            hold_pc_d  = head_addr_c + PC_WIDTH'(2);
            hold_vld_d = 1'b1;
            state_d    = ST_HALF;
          end
        end else begin
          data_c = head_word_c;
          if (valid_c && bus.instr_ready_i) pop_c = 1'b1;
        end
      end

      ST_HALF: begin
        pc_c = hold_pc_q;
        if (is_rvc(hold_q)) begin
          valid_c = 1'b1;
          data_c  = {16'h0, hold_q};
          if (bus.instr_ready_i) begin
            hold_vld_d = 1'b0;
            state_d    = ST_ALIGNED;
          end
        end else begin
          valid_c = head_vld_c;
          data_c  = {head_word_c[15:0], hold_q};
          if (valid_c && bus.instr_ready_i) begin
            pop_c     = 1'b1;
            hold_d    = head_word_c[31:16];
            hold_pc_d = head_addr_c + PC_WIDTH'(2);
          end
        end
      end

      ST_SKIP: begin
        if (head_vld_c) begin
          pop_c      = 1'b1;
          hold_d     = head_word_c[31:16];
          hold_pc_d  = head_addr_c + PC_WIDTH'(2);
          hold_vld_d = 1'b1;
          state_d    = ST_HALF;
        end
      end

      default: begin
        state_d    = ST_ALIGNED;
        hold_vld_d = 1'b0;
      end
    endcase

    if (bus.branch_i) begin
      state_d    = bus.branch_addr_i[1] ? ST_SKIP : ST_ALIGNED;
      hold_d     = '0;
      hold_pc_d  = '0;
      hold_vld_d = 1'b0;
      pop_c      = 1'b0;
    end
  end

  assign bus.fetch_ready_o         = ~fifo_full;
  assign bus.instr_valid_o         = valid_c;
  assign bus.instr_rdata_o         = valid_c ? data_c : '0;
  assign bus.instr_pc_o            = valid_c ? pc_c : '0;
  assign bus.instr_is_compressed_o = valid_c & is_rvc(data_c[15:0]);
  assign bus.busy_o                = ~fifo_empty | hold_vld_q;

endmodule

// File: tb/tb_riscv_if_aligner_fifo.sv
// Scoreboard bench for riscv_if_aligner_fifo: a halfword-stream model predicts
// the instruction sequence; a monitor checks every output handshake.
module tb_riscv_if_aligner_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PCW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_if_aligner_fifo_if #(.PC_WIDTH(PCW)) bus();

  riscv_if_aligner_fifo #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        cmp;
  } exp_t;

  exp_t        expq[$];
  logic [47:0] hwq[$];      // {pc, halfword} of the fetched stream not yet formed into instructions
  logic        skip_first = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Turn buffered halfwords into complete instructions
  task automatic build_expect();
    logic [47:0] a;
    logic [47:0] b;
    exp_t        e;
    while (hwq.size() > 0) begin
      a = hwq[0];
      if (a[1:0] != 2'b11) begin
        e.data = {16'h0, a[15:0]};
        e.pc   = a[47:16];
        e.cmp  = 1'b1;
        expq.push_back(e);
        void'(hwq.pop_front());
      end else if (hwq.size() >= 2) begin
        b = hwq[1];
        e.data = {b[15:0], a[15:0]};
        e.pc   = a[47:16];
        e.cmp  = 1'b0;
        expq.push_back(e);
        void'(hwq.pop_front());
        void'(hwq.pop_front());
      end else begin
        break;
      end
    end
  endtask

  // Reference model: observes accepted words and branches on the upcoming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      hwq.delete();
      expq.delete();
      skip_first <= 1'b0;
    end else if (bus.branch_i) begin
      hwq.delete();
      expq.delete();
      skip_first <= bus.branch_addr_i[1];
    end else if (bus.fetch_valid_i && bus.fetch_ready_o) begin
      if (!skip_first) hwq.push_back({bus.fetch_addr_i, bus.fetch_rdata_i[15:0]});
      hwq.push_back({bus.fetch_addr_i + 32'd2, bus.fetch_rdata_i[31:16]});
      skip_first <= 1'b0;
      build_expect();
    end
  end

  logic        mon_held = 1'b0;
  logic [63:0] mon_prev = '0;

  // Monitor: compares each transfer against the scoreboard, and stalled outputs for stability
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      mon_held = 1'b0;
    end else begin
      if (mon_held) begin
        chk("stall_valid", 64'(bus.instr_valid_o), 64'd1);
        chk("stall_data", {bus.instr_rdata_o, bus.instr_pc_o}, mon_prev);
      end
      if (bus.instr_valid_o && bus.instr_ready_i && !bus.branch_i) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_instr actual=0x%0h pc=0x%0h expected=none", bus.instr_rdata_o, bus.instr_pc_o);
        end else begin
          e = expq.pop_front();
          chk("instr_rdata", 64'(bus.instr_rdata_o), 64'(e.data));
          chk("instr_pc", 64'(bus.instr_pc_o), 64'(e.pc));
          chk("instr_is_compressed", 64'(bus.instr_is_compressed_o), 64'(e.cmp));
        end
      end
      mon_held = bus.instr_valid_o && !bus.instr_ready_i && !bus.branch_i;
      mon_prev = {bus.instr_rdata_o, bus.instr_pc_o};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] a);
    logic acc;
    logic done;
    done = 1'b0;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_rdata_i = w;
    bus.fetch_addr_i  = a;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      acc = bus.fetch_ready_o;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    bus.fetch_valid_i = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=not_accepted expected=accepted addr=0x%0h", a);
    end
  endtask

  task automatic branch_to(input logic [31:0] a);
    bus.branch_i      = 1'b1;
    bus.branch_addr_i = a;
    tick();
    bus.branch_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && expq.size() != 0; n++) tick();
    tick();
    chk(name, 64'(expq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr_valid"}, 64'(bus.instr_valid_o), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_instr_rdata"}, 64'(bus.instr_rdata_o), 64'd0);
    chk({tag, "_instr_pc"}, 64'(bus.instr_pc_o), 64'd0);
    chk({tag, "_fetch_ready"}, 64'(bus.fetch_ready_o), 64'd1);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  initial begin
    logic [31:0] nxt;
    logic [31:0] w;
    logic [31:0] tgt;
    logic        acc;

    bus.branch_i      = 1'b0;
    bus.branch_addr_i = '0;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_rdata_i = '0;
    bus.fetch_addr_i  = '0;
    bus.instr_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Aligned 32-bit stream
    bus.instr_ready_i = 1'b1;
    push_word(32'h00000013, 32'h100);
`ifndef RISCV_IF_ALIGNER_BYPASS_EN
    chk("aligned_first_valid", 64'(bus.instr_valid_o), 64'd1);
    chk("aligned_first_data", 64'(bus.instr_rdata_o), 64'h13);
    chk("aligned_first_pc", 64'(bus.instr_pc_o), 64'h100);
`endif
    push_word(32'h00100093, 32'h104);
    drain("drain_aligned");

    // Two compressed instructions in one word
    branch_to(32'h200);
    push_word(32'h00014501, 32'h200);
`ifndef RISCV_IF_ALIGNER_BYPASS_EN
    chk("rvc_pair_first", {bus.instr_rdata_o, bus.instr_pc_o}, {32'h00004501, 32'h200});
    tick();
`endif
    chk("rvc_pair_second", {bus.instr_rdata_o, bus.instr_pc_o}, {32'h00000001, 32'h202});
    chk("rvc_pair_second_cmp", 64'(bus.instr_is_compressed_o), 64'd1);
    tick();
    chk("rvc_pair_done_valid", 64'(bus.instr_valid_o), 64'd0);
    chk("rvc_pair_done_busy", 64'(bus.busy_o), 64'd0);

    // 32-bit instruction straddling a word boundary
    branch_to(32'h300);
    push_word(32'h05930001, 32'h300);
    push_word(32'h00010010, 32'h304);
    drain("drain_straddle");

    // Branch to an odd halfword: one bubble, then the upper half
    branch_to(32'h402);
    push_word(32'h45014581, 32'h400);
    chk("skip_bubble", 64'(bus.instr_valid_o), 64'd0);
    tick();
    chk("skip_out", {bus.instr_rdata_o, bus.instr_pc_o}, {32'h00004501, 32'h402});
    drain("drain_skip");

    // Backpressure: FIFO fills after DEPTH words, extra word refused
    bus.instr_ready_i = 1'b0;
    branch_to(32'h500);
    for (int k = 0; k < DEPTH; k++) push_word(32'h00000013 | (32'(k) << 20), 32'h500 + 32'(4 * k));
    bus.fetch_valid_i = 1'b1;
    bus.fetch_rdata_i = 32'h00000093;
    bus.fetch_addr_i  = 32'h500 + 32'(4 * DEPTH);
    for (int k = 0; k < 3; k++) begin
      chk("full_fetch_ready", 64'(bus.fetch_ready_o), 64'd0);
      tick();
    end
    bus.fetch_valid_i = 1'b0;
    chk("full_head", {bus.instr_rdata_o, bus.instr_pc_o}, {32'h00000013, 32'h500});
    bus.instr_ready_i = 1'b1;
    drain("drain_backpressure");

    // Branch with a concurrent push while holding an incomplete 32-bit half
    branch_to(32'h600);
    push_word(32'h00134501, 32'h600);
    tick();
    bus.branch_i      = 1'b1;
    bus.branch_addr_i = 32'h700;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_rdata_i = 32'hdeadbeef;
    bus.fetch_addr_i  = 32'h700;
    tick();
    bus.branch_i      = 1'b0;
    bus.fetch_valid_i = 1'b0;
    chk("branch_flush_busy", 64'(bus.busy_o), 64'd0);
    chk("branch_flush_valid", 64'(bus.instr_valid_o), 64'd0);

    // Reset mid-operation discards buffered words
    bus.instr_ready_i = 1'b0;
    push_word(32'h00000013, 32'h700);
    chk("pre_reset_busy", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized stream with backpressure and occasional branches
    nxt = 32'h1000;
    w   = {rand_hw(), rand_hw()};
    for (int i = 0; i < 3000; i++) begin
      bus.instr_ready_i = ($urandom_range(9, 0) < 6);
      bus.fetch_rdata_i = w;
      bus.fetch_addr_i  = nxt;
      bus.fetch_valid_i = ($urandom_range(9, 0) < 7);
      if ($urandom_range(49, 0) == 0) begin
        tgt = 32'($urandom) & 32'hFFFF_FFFE;
        if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hE);
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = tgt;
      end else begin
        bus.branch_i = 1'b0;
      end
      @(negedge clk);
      acc = bus.fetch_valid_i & bus.fetch_ready_o & ~bus.branch_i;
      @(posedge clk);
      #1;
      if (bus.branch_i) begin
        nxt = tgt & 32'hFFFF_FFFC;
        w   = {rand_hw(), rand_hw()};
      end else if (acc) begin
        nxt = nxt + 32'd4;
        w   = {rand_hw(), rand_hw()};
      end
    end
    bus.branch_i      = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
